can_bit_timing: RTL
===================

// Module: can_bit_timing
// PURPOSE
//  CAN bit-timing unit between the synchronized ui_in RX pin and the CAN protocol engine.
//  Divides clk into time quanta (tq) and tracks the bit segments SYNC / TSEG1 / TSEG2.
//  Hard-syncs and resyncs on recessive->dominant edges.
//  Emits the sampled RX bit at the sample point and a transmit strobe at each bit start.
// PARAMETERS
//  BRP_W    6  width of baud-rate prescaler field
//  TSEG1_W  4  width of TSEG1 field (prop + phase1)
//  TSEG2_W  3  width of TSEG2 field (phase2)
//  SJW_W    2  width of sync-jump-width field
// PORTS
//  clk           in   1        system clock
//  rst_n         in   1        asynchronous active-low reset
//  rx_in         in   1        CAN RX, already 2-stage synchronized; 1=recessive
//  brp           in   BRP_W    tq = brp+1 clk
//  tseg1         in   TSEG1_W  TSEG1 = tseg1+1 tq
//  tseg2         in   TSEG2_W  TSEG2 = tseg2+1 tq
//  sjw           in   SJW_W    SJW = sjw+1 tq
//  hard_sync_en  in   1        engine idle/expecting SOF: next edge hard-syncs
//  rx_bit        out  1        sampled bus value
//  sample_strobe out  1        1-clk pulse; rx_bit valid from this cycle
//  tx_strobe     out  1        1-clk pulse on first clk of SYNC; engine drives TX here
//  sync_event    out  1        1-clk pulse when a hard sync or resync is applied
// BEHAVIOUR
//  Reset: rx_bit=1; all strobes 0; segment=SYNC; prescaler and tq counters 0.
//  Reset mid-bit aborts at once; first tx_strobe comes on the first clk after reset release.
//  Prescaler: counts 0..brp and issues tq_tick at brp. Bit period = (1+tseg1+1+tseg2+1) tq.
//  brp, tseg1, tseg2 and sjw are latched at each tx_strobe. Mid-bit changes take effect next bit.
//  Effective SJW = min(sjw+1, tseg2+1).
//  Segment FSM:
//   SYNC (1 tq) -> TSEG1 (tseg1+1+ext tq) -> sample point -> TSEG2 (tseg2+1-short tq) -> SYNC.
//  sample_strobe is asserted on the clk of the final tq_tick of TSEG1.
//   rx_bit <= rx_in on that same edge, so it is visible the next cycle.
//  edge: rx_d==1 && rx_in==0, where rx_d is a 1-clk delayed rx_in.
//   An edge is usable only if the last sampled rx_bit==1.
//   At most one sync action (hard or re) per bit, counted from sample point to sample point.
//  Hard sync:
//   Trigger: usable edge while hard_sync_en.
//   Action: prescaler cleared, segment forced to TSEG1 with tq index 0, ext/short cleared.
//   Result: sample_strobe exactly (tseg1+1)*(brp+1) clk after the edge cycle.
//  Resync, edge in TSEG1 at tq index k (0-based):
//   ext = min(k+1, SJW), so the sample point moves later.
//  Resync, edge in TSEG2 at tq index k:
//   short = min(tseg2+1-k, SJW).
//   If short >= remaining tq, the bit ends at the next tq_tick.
//  Edge during SYNC: phase error 0, no adjustment. sync_event still pulses.
//  An edge coinciding with a sample_strobe is treated as belonging to TSEG2 of the current bit.
// CONFIGURATION
//  CAN_BTU_TRIPLE_SAMPLE_EN defined:
//   rx_in is captured on the tq_ticks ending tq N-2, N-1 and N of TSEG1.
//   rx_bit = majority of the 3 captures; tseg1 < 2 falls back to single sample.
//  CAN_BTU_TRIPLE_SAMPLE_EN undefined: single sample at the sample point only.
//  Strobe timing is identical in both builds.
// STRUCTURE
//  Shared package/header can_pkg: segment encoding SEG_SYNC/SEG_TSEG1/SEG_TSEG2, default
//  field widths, and reset values.
//  Sub-module can_tq_prescaler: counter with sync clear, outputs tq_tick.
//  The FSM, edge logic and sampling stay in can_bit_timing.
// TESTING (brp=1, tseg1=5, tseg2=2, sjw=1 unless stated: 10 tq = 20 clk/bit)
//  Idle rx_in=1, no edges -> tx_strobe every 20 clk; sample_strobe 14 clk after each tx_strobe.
//  hard_sync_en=1, falling edge at cycle N -> sync_event at N, sample_strobe at N+12,
//   next tx_strobe at N+18.
//  Edge in TSEG1 tq index 2 -> sample_strobe 4 clk later than nominal; bit lasts 24 clk.
//  sjw=0, edge in TSEG2 tq index 1 -> bit shortened by 1 tq (18 clk); sync_event pulses once.
//  Second edge in the same bit, or edge while rx_bit==0 -> no timing change, no sync_event.
//  Assert rst_n mid-TSEG1 -> outputs at reset values immediately; after release,
//   first tx_strobe on the first clk.
//   TRIPLE_SAMPLE build: rx_in 1,0,1 across the 3 captures -> rx_bit=1.

Source files
------------

// File: rtl/can_pkg.sv
// Shared definitions for the CAN bit-timing unit: segment encoding,
// default field widths, reset values and small helper functions.
// Optional feature macro used by can_bit_timing: CAN_BTU_TRIPLE_SAMPLE_EN.
package can_pkg;

    localparam int CAN_BRP_W   = 6;
    localparam int CAN_TSEG1_W = 4;
    localparam int CAN_TSEG2_W = 3;
    localparam int CAN_SJW_W   = 2;

    typedef enum logic [1:0] {
        SEG_SYNC  = 2'd0,
        SEG_TSEG1 = 2'd1,
        SEG_TSEG2 = 2'd2
    } seg_t;

    localparam seg_t SEG_RESET = SEG_SYNC;
    localparam logic RX_RESET  = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/can_tq_prescaler.sv
// Time-quantum prescaler: counts 0..brp and pulses tick on the count equal
// to brp. A synchronous clear makes the current cycle count as 0, so a hard
// sync cycle is itself the first clk of a fresh time quantum.
module can_tq_prescaler #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [W-1:0] brp,
    output logic         tick,
    output logic         at_zero
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_eff;

    // Effective count for this cycle and the tick decode.
    always_comb begin
        cnt_eff = clear ? '0 : cnt;
        tick    = (cnt_eff == brp);
    end

    // Counter register: wraps to 0 after the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt_eff + W'(1);
    end

    assign at_zero = (cnt == '0);

endmodule

// File: rtl/can_bit_timing.sv
// CAN bit-timing unit: tracks SYNC / TSEG1 / TSEG2 in time quanta, applies
// hard sync and resync on usable recessive->dominant edges, samples the bus
// at the sample point and strobes the protocol engine at each bit start.
// Optional feature: define CAN_BTU_TRIPLE_SAMPLE_EN for 3-point majority
// sampling (strobe timing is the same either way).
// Handshake: none; tx_strobe, sample_strobe and sync_event are single-cycle
// pulses, and rx_bit holds the sampled value from the sample_strobe cycle on.
module can_bit_timing
    import can_pkg::*;
#(
    parameter int BRP_W   = CAN_BRP_W,
    parameter int TSEG1_W = CAN_TSEG1_W,
    parameter int TSEG2_W = CAN_TSEG2_W,
    parameter int SJW_W   = CAN_SJW_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_in,
    input  logic [BRP_W-1:0]   brp,
    input  logic [TSEG1_W-1:0] tseg1,
    input  logic [TSEG2_W-1:0] tseg2,
    input  logic [SJW_W-1:0]   sjw,
    input  logic               hard_sync_en,
    output logic               rx_bit,
    output logic               sample_strobe,
    output logic               tx_strobe,
    output logic               sync_event
);

    // Wide enough for TSEG1 length plus the largest phase extension.
    localparam int TQ_W = max3(TSEG1_W, TSEG2_W, SJW_W) + 2;
    localparam logic [TQ_W-1:0] TQ_ONE = TQ_W'(1);

    // FSM state bundle; st is the observable state for debug/checkers.
    typedef struct packed {
        seg_t            seg;
        logic [TQ_W-1:0] tq;
        logic [TQ_W-1:0] ext;
        logic [TQ_W-1:0] shrt;
        logic            synced;
    } bt_state_t;

    bt_state_t st, cur, nxt;

    logic [BRP_W-1:0]   brp_q,   brp_e;
    logic [TSEG1_W-1:0] tseg1_q, tseg1_e;
    logic [TSEG2_W-1:0] tseg2_q, tseg2_e;
    logic [SJW_W-1:0]   sjw_q,   sjw_e;
    logic [TQ_W-1:0]    t1_len, t2_len, sjw_len, sjw_eff, rem;

    logic rx_d;
    logic fall_edge, usable, hard, resync;
    logic tq_tick, presc_zero;
    logic sample_nx;

`ifdef CAN_BTU_TRIPLE_SAMPLE_EN
    logic [1:0] cap;
    logic       cap_adv;
`endif

    // Bit start: first clk of SYNC, suppressed while reset is held.
    assign tx_strobe  = rst_n & (st.seg == SEG_SYNC) & presc_zero;
    assign sync_event = usable;

    // Timing fields: the live inputs on the bit-start cycle, latched otherwise.
    always_comb begin
        brp_e   = tx_strobe ? brp   : brp_q;
        tseg1_e = tx_strobe ? tseg1 : tseg1_q;
        tseg2_e = tx_strobe ? tseg2 : tseg2_q;
        sjw_e   = tx_strobe ? sjw   : sjw_q;
        t1_len  = TQ_W'(tseg1_e) + TQ_ONE;
        t2_len  = TQ_W'(tseg2_e) + TQ_ONE;
        sjw_len = TQ_W'(sjw_e) + TQ_ONE;
        sjw_eff = (sjw_len < t2_len) ? sjw_len : t2_len;
    end

    can_tq_prescaler #(.W(BRP_W)) u_presc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (hard),
        .brp     (brp_e),
        .tick    (tq_tick),
        .at_zero (presc_zero)
    );

    // Edge qualification and the sync adjustment applied to the current state.
    always_comb begin
        fall_edge = rx_d & ~rx_in;
        usable    = rst_n & fall_edge & rx_bit & ~st.synced;
        hard      = usable & hard_sync_en;
        resync    = usable & ~hard_sync_en;
        rem       = t2_len - st.tq;
        cur       = st;
        if (hard) begin
            cur.seg  = SEG_TSEG1;
            cur.tq   = '0;
            cur.ext  = '0;
            cur.shrt = '0;
        end else if (resync && st.seg == SEG_TSEG1) begin
            cur.ext = ((st.tq + TQ_ONE) < sjw_eff) ? (st.tq + TQ_ONE) : sjw_eff;
        end else if (resync && st.seg == SEG_TSEG2) begin
            cur.shrt = (rem < sjw_eff) ? rem : sjw_eff;
        end
    end

    // Segment FSM next state, advanced on each tq_tick.
    always_comb begin
        nxt        = cur;
        nxt.synced = st.synced | usable;
        sample_nx  = 1'b0;
        if (tq_tick) begin
            case (cur.seg)
                SEG_SYNC: begin
                    nxt.seg = SEG_TSEG1;
                    nxt.tq  = '0;
                end
                SEG_TSEG1: begin
                    if ((cur.tq + TQ_ONE) >= (t1_len + cur.ext)) begin
                        nxt.seg    = SEG_TSEG2;
                        nxt.tq     = '0;
                        nxt.synced = 1'b0;
                        sample_nx  = 1'b1;
                    end else begin
                        nxt.tq = cur.tq + TQ_ONE;
                    end
                end
                SEG_TSEG2: begin
                    if ((cur.tq + TQ_ONE) >= (t2_len - cur.shrt)) begin
                        nxt.seg  = SEG_SYNC;
                        nxt.tq   = '0;
                        nxt.ext  = '0;
                        nxt.shrt = '0;
                    end else begin
                        nxt.tq = cur.tq + TQ_ONE;
                    end
                end
                default: begin
                    nxt.seg = SEG_SYNC;
                    nxt.tq  = '0;
                end
            endcase
        end
    end

`ifdef CAN_BTU_TRIPLE_SAMPLE_EN
    // Early captures happen on every non-final TSEG1 tick; the last two remain.
    assign cap_adv = tq_tick & (cur.seg == SEG_TSEG1) & ~sample_nx;
`endif

    // Segment FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st.seg    <= SEG_RESET;
            st.tq     <= '0;
            st.ext    <= '0;
            st.shrt   <= '0;
            st.synced <= 1'b0;
        end else begin
            st <= nxt;
        end
    end

    // Sampling, edge history and field latching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_d          <= 1'b1;
            rx_bit        <= RX_RESET;
            sample_strobe <= 1'b0;
            brp_q         <= '0;
            tseg1_q       <= '0;
            tseg2_q       <= '0;
            sjw_q         <= '0;
`ifdef CAN_BTU_TRIPLE_SAMPLE_EN
            cap           <= 2'b11;
`endif
        end else begin
            rx_d          <= rx_in;
            sample_strobe <= sample_nx;
            if (tx_strobe) begin
                brp_q   <= brp;
                tseg1_q <= tseg1;
                tseg2_q <= tseg2;
                sjw_q   <= sjw;
            end
`ifdef CAN_BTU_TRIPLE_SAMPLE_EN
            if (cap_adv)
                cap <= {cap[0], rx_in};
            if (sample_nx) begin
                if (tseg1_e >= TSEG1_W'(2))
                    rx_bit <= majority3(cap[1], cap[0], rx_in);
                else
                    rx_bit <= rx_in;
            end
`else
            if (sample_nx)
                rx_bit <= rx_in;
`endif
        end
    end

endmodule
